rn_req_ctrl: RTL and testbench

- Request-node issue/return controller; sits directly upstream of the slave node (sn) on the request/data channel pair.
- Accepts core-side requests into a small FIFO and issues them one at a time on the two-phase channel: pre_tx_req, then v_tx_req plus payload.
- Waits for the slave's two-phase data return (pre_rx_data / v_rx_data) and hands the result back to the core with a valid/ready handshake.
- One outstanding transaction at a time.

---
 rtl/rn_req_ctrl_pkg.sv | 45 ++++
 rtl/rn_req_ctrl_if.sv | 45 ++++
 rtl/rn_req_ctrl_fifo.sv | 55 +++++
 rtl/rn_req_ctrl.sv | 134 +++++++++++++
 tb/tb_rn_req_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rn_req_ctrl_pkg.sv
// Shared node types: request/data payloads, opcodes and the RN FSM state.
// Imported by the rn_req_ctrl controller, its FIFO and its bus interface.
package node_package;

  localparam int WORD_WIDTH = 32;
  localparam int ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    op_none      = 2'd0,
    op_read      = 2'd1,
    op_write     = 2'd2,
    op_data_recv = 2'd3
  } OpType;

  typedef struct packed {
    OpType                 opcode;
    logic [ADDR_WIDTH-1:0] addr;
  } ReqType;

  typedef struct packed {
    OpType                 opcode;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WORD_WIDTH-1:0] data;
  } DataType;

  typedef enum logic [1:0] {
    CHN_IDLE  = 2'd0,
    CHN_PRE   = 2'd1,
    CHN_VALID = 2'd2
  } Type_chn_state;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SEND = 3'd2,
    ST_WAIT = 3'd3,
    ST_RSP  = 3'd4
  } RnState;

  // A return is bad if it is not a data return or targets another address.
  function automatic logic rsp_bad(DataType rx, ReqType rq);
    return (rx.opcode != op_data_recv) || (rx.addr != rq.addr);
  endfunction

endpackage

// File: rtl/rn_req_ctrl_if.sv
// Core request/response and slave request/data channel bundle.
// master = the request node, slave = the core plus slave node side.
interface rn_req_ctrl_if;
  import node_package::*;

  logic                  core_req_valid;
  ReqType                core_req;
  logic                  core_req_ready;

  logic                  pre_tx_req;
  ReqType                tx_req;
  logic                  v_tx_req;

  logic                  pre_rx_data;
  DataType               rx_data;
  logic                  v_rx_data;

  logic                  rsp_valid;
  logic [WORD_WIDTH-1:0] rsp_data;
  logic                  rsp_err;
  logic                  rsp_ready;

  logic                  busy;

  modport master (
    input  core_req_valid, core_req,
    input  pre_rx_data, rx_data, v_rx_data,
    input  rsp_ready,
    output core_req_ready,
    output pre_tx_req, tx_req, v_tx_req,
    output rsp_valid, rsp_data, rsp_err,
    output busy
  );

  modport slave (
    output core_req_valid, core_req,
    output pre_rx_data, rx_data, v_rx_data,
    output rsp_ready,
    input  core_req_ready,
    input  pre_tx_req, tx_req, v_tx_req,
    input  rsp_valid, rsp_data, rsp_err,
    input  busy
  );

endinterface

// File: rtl/rn_req_ctrl_fifo.sv
// DEPTH x ReqType synchronous FIFO holding core requests.
// Head is read combinationally; no write-to-read bypass.
module rn_req_fifo
  import node_package::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  input  logic   push,
  input  logic   pop,
  input  ReqType din,
  output ReqType dout,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  ReqType          mem_q [DEPTH];
  logic [AW-1:0]   wr_q;
  logic [AW-1:0]   rd_q;
  logic [AW:0]     cnt_q;
  logic            do_push;
  logic            do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_q];

  // Pointers wrap naturally at DEPTH; count tracks occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array; contents are qualified by the count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/rn_req_ctrl.sv
// Request-node issue/return controller, one transaction in flight.
// Optional ST_WAIT timeout is enabled by defining RN_TIMEOUT_EN.
module rn_req_ctrl
  import node_package::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  rn_req_ctrl_if.master bus
);

  RnState                state_q;
  ReqType                buf_q;
  logic                  pre_q;
  logic                  vtx_q;
  logic                  rspv_q;
  logic [WORD_WIDTH-1:0] rspd_q;
  logic                  err_q;
  logic                  busy_q;

  ReqType                head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;

  logic                  unused_pre;

  assign unused_pre = bus.pre_rx_data;

  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;

  rn_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (bus.core_req_valid),
    .pop     (fifo_pop),
    .din     (bus.core_req),
    .dout    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign bus.core_req_ready = !fifo_full;
  assign bus.pre_tx_req     = pre_q;
  assign bus.v_tx_req       = vtx_q;
  assign bus.tx_req         = buf_q;
  assign bus.rsp_valid      = rspv_q;
  assign bus.rsp_data       = rspd_q;
  assign bus.rsp_err        = err_q;
  assign bus.busy           = busy_q;

`ifdef RN_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  // Moore FSM; every channel output is registered on the transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      pre_q   <= 1'b0;
      vtx_q   <= 1'b0;
      rspv_q  <= 1'b0;
      rspd_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef RN_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      pre_q <= 1'b0;
      vtx_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            buf_q   <= head;
            state_q <= ST_PRE;
            pre_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_PRE: begin
          state_q <= ST_SEND;
          vtx_q   <= 1'b1;
        end
        ST_SEND: begin
          state_q <= ST_WAIT;
`ifdef RN_TIMEOUT_EN
          tmo_q   <= '0;
`endif
        end
        ST_WAIT: begin
          if (bus.v_rx_data) begin
            state_q <= ST_RSP;
            rspv_q  <= 1'b1;
            rspd_q  <= bus.rx_data.data;
            err_q   <= rsp_bad(bus.rx_data, buf_q);
`ifdef RN_TIMEOUT_EN
          end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_q <= ST_RSP;
            rspv_q  <= 1'b1;
            rspd_q  <= '0;
            err_q   <= 1'b1;
          end else begin
            tmo_q   <= tmo_q + 1'b1;
`endif
          end
        end
        ST_RSP: begin
          if (bus.rsp_ready) begin
            state_q <= ST_IDLE;
            rspv_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rspv_q  <= 1'b0;
          err_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rn_req_ctrl.sv
// Directed bench for rn_req_ctrl with a response scoreboard queue.
// Build with RN_TIMEOUT_EN to exercise the ST_WAIT timeout.
module tb_rn_req_ctrl;
  import node_package::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rn_req_ctrl_if bus();

  rn_req_ctrl #(
    .DEPTH          (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  int   vec  = 0;
  int   errs = 0;
  exp_t sbq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_req(OpType op, logic [15:0] a);
    int n = 0;
    bus.core_req_valid = 1'b1;
    bus.core_req = '{opcode: op, addr: a};
    while (bus.core_req_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("push_ready", bus.core_req_ready, 1);
    tick();
    bus.core_req_valid = 1'b0;
  endtask

  task automatic wait_send(output logic [15:0] a);
    int n = 0;
    while (bus.v_tx_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("send_seen", bus.v_tx_req, 1);
    a = bus.tx_req.addr;
  endtask

  task automatic check_rsp(string tag);
    exp_t e;
    chk({tag, "_valid"}, bus.rsp_valid, 1);
    if (sbq.size() == 0) begin
      vec++;
      errs++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_data"}, bus.rsp_data, e.data);
      chk({tag, "_err"}, bus.rsp_err, e.err);
    end
  endtask

  task automatic return_data(string tag, OpType op, logic [15:0] a,
                             logic [31:0] d, logic e);
    bus.v_rx_data = 1'b1;
    bus.rx_data = '{opcode: op, addr: a, data: d};
    sbq.push_back('{data: d, err: e});
    tick();
    bus.v_rx_data = 1'b0;
    check_rsp(tag);
  endtask

  task automatic ack();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("rsp_drop", bus.rsp_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    logic        seen;
    bus.core_req_valid = 1'b0;
    bus.core_req       = '0;
    bus.pre_rx_data    = 1'b0;
    bus.rx_data        = '0;
    bus.v_rx_data      = 1'b0;
    bus.rsp_ready      = 1'b0;

    // reset state
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_pre", bus.pre_tx_req, 0);
    chk("rst_vtx", bus.v_tx_req, 0);
    chk("rst_txreq", bus.tx_req, 0);
    chk("rst_rspv", bus.rsp_valid, 0);
    chk("rst_rspd", bus.rsp_data, 0);
    chk("rst_rspe", bus.rsp_err, 0);
    chk("rst_ready", bus.core_req_ready, 1);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // single read, exact latency
    bus.core_req_valid = 1'b1;
    bus.core_req = '{opcode: op_read, addr: 16'd3};
    chk("rd_ready", bus.core_req_ready, 1);
    tick();
    bus.core_req_valid = 1'b0;
    chk("rd_pre_n1", bus.pre_tx_req, 0);
    tick();
    chk("rd_pre_n2", bus.pre_tx_req, 1);
    chk("rd_vtx_n2", bus.v_tx_req, 0);
    chk("rd_busy", bus.busy, 1);
    tick();
    chk("rd_vtx_n3", bus.v_tx_req, 1);
    chk("rd_pre_n3", bus.pre_tx_req, 0);
    chk("rd_addr", bus.tx_req.addr, 3);
    chk("rd_op", bus.tx_req.opcode, op_read);
    tick();
    chk("rd_vtx_n4", bus.v_tx_req, 0);
    chk("rd_hold", bus.tx_req.addr, 3);
    bus.pre_rx_data = 1'b1;
    tick();
    bus.pre_rx_data = 1'b0;
    return_data("rd", op_data_recv, 16'd3, 32'h3, 1'b0);
    ack();
    chk("rd_idle", bus.busy, 0);

    // stray return while idle
    bus.v_rx_data = 1'b1;
    bus.rx_data = '{opcode: op_data_recv, addr: 16'd3, data: 32'h99};
    tick();
    bus.v_rx_data = 1'b0;
    chk("stray_v", bus.rsp_valid, 0);
    tick();
    chk("stray_v2", bus.rsp_valid, 0);
    chk("stray_busy", bus.busy, 0);

    // address and opcode mismatch
    push_req(op_read, 16'd5);
    wait_send(a);
    chk("mm_addr", a, 5);
    tick();
    return_data("mm_addr", op_data_recv, 16'd6, 32'h55, 1'b1);
    ack();
    push_req(op_write, 16'h11);
    wait_send(a);
    chk("mm_op_addr", a, 16'h11);
    chk("mm_op_op", bus.tx_req.opcode, op_write);
    tick();
    return_data("mm_op", op_read, 16'h11, 32'h77, 1'b1);
    ack();

    // FIFO full behind a stalled transaction
    push_req(op_read, 16'h20);
    wait_send(a);
    chk("ff_first", a, 16'h20);
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.core_req_valid = 1'b1;
      bus.core_req.opcode = i[0] ? op_write : op_read;
      bus.core_req.addr = 16'(i);
      chk("ff_ready", bus.core_req_ready, 1);
      tick();
    end
    bus.core_req.addr = 16'd9;
    chk("ff_full", bus.core_req_ready, 0);
    tick();
    bus.core_req_valid = 1'b0;
    chk("ff_full2", bus.core_req_ready, 0);
    return_data("ff_stall", op_data_recv, 16'h20, 32'hAA, 1'b0);
    ack();
    for (int i = 0; i < 4; i++) begin
      wait_send(a);
      chk("ff_order", a, 64'(i));
      tick();
      return_data("ff_rsp", op_data_recv, 16'(i), 32'hA0 + 32'(i), 1'b0);
      ack();
    end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.pre_tx_req || bus.v_tx_req) seen = 1'b1;
    end
    chk("ff_nodrop", seen, 0);
    chk("ff_ready_end", bus.core_req_ready, 1);

    // response backpressure
    push_req(op_read, 16'd7);
    push_req(op_read, 16'd8);
    wait_send(a);
    chk("bp_addr7", a, 7);
    tick();
    return_data("bp7", op_data_recv, 16'd7, 32'h7007, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h7007)
        seen = 1'b1;
      if (bus.pre_tx_req !== 1'b0) seen = 1'b1;
    end
    chk("bp_stable", seen, 0);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    chk("bp_r1_v", bus.rsp_valid, 0);
    chk("bp_r1_pre", bus.pre_tx_req, 0);
    tick();
    chk("bp_r2_pre", bus.pre_tx_req, 1);
    wait_send(a);
    chk("bp_addr8", a, 8);
    tick();
    return_data("bp8", op_data_recv, 16'd8, 32'h8008, 1'b0);
    ack();

    // reset while waiting with two requests queued
    push_req(op_read, 16'h30);
    wait_send(a);
    tick();
    push_req(op_read, 16'h31);
    push_req(op_read, 16'h32);
    chk("rw_busy", bus.busy, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rw_busy0", bus.busy, 0);
    chk("rw_pre0", bus.pre_tx_req, 0);
    chk("rw_vtx0", bus.v_tx_req, 0);
    chk("rw_tx0", bus.tx_req, 0);
    chk("rw_rspv0", bus.rsp_valid, 0);
    chk("rw_ready1", bus.core_req_ready, 1);
    tick();
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.pre_tx_req || bus.v_tx_req || bus.busy) seen = 1'b1;
    end
    chk("rw_quiet", seen, 0);
    push_req(op_read, 16'h44);
    wait_send(a);
    chk("rw_after", a, 16'h44);
    tick();
    return_data("rw_after", op_data_recv, 16'h44, 32'h4444, 1'b0);
    ack();

`ifdef RN_TIMEOUT_EN
    // timeout after 8 wait cycles
    push_req(op_read, 16'h50);
    wait_send(a);
    tick();
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("tmo_early", seen, 0);
    sbq.push_back('{data: 32'h0, err: 1'b1});
    check_rsp("tmo");
    ack();
    // data on the last wait cycle beats the timeout
    push_req(op_read, 16'h51);
    wait_send(a);
    tick();
    for (int i = 0; i < 7; i++) tick();
    return_data("tmo_race", op_data_recv, 16'h51, 32'h1234, 1'b0);
    ack();
`else
    // no timeout: wait indefinitely
    push_req(op_read, 16'h50);
    wait_send(a);
    tick();
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("no_tmo", seen, 0);
    chk("no_tmo_busy", bus.busy, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
